// File: rtl/huffman_pkg.sv
// Shared constants, FSM state type and helpers for the Huffman stream encoder
// and the 128-entry code table it reads.
package huffman_pkg;

  localparam int SYM_W       = 7;
  localparam int LEN_W       = 7;
  localparam int CODE_W      = 128;
  localparam int TABLE_DEPTH = 128;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    SEND
  } encState_t;

  function automatic logic [7:0] minU8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/huff_bit_merge.sv
// Combinational merge of the next k code bits (MSB-first) into the output word
// at the current fill offset; k = min(remaining code bits, free word bits).
module huff_bit_merge
  import huffman_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [OUT_W-1:0]       word,
  input  logic [$clog2(OUT_W):0] fill,
  input  logic [LEN_W-1:0]       rem,
  input  logic [CODE_W-1:0]      code,
  output logic [OUT_W-1:0]       newWord,
  output logic [$clog2(OUT_W):0] k,
  output logic [LEN_W-1:0]       newRem
);

  localparam int FILL_W = $clog2(OUT_W) + 1;

  logic [7:0]       room;
  logic [7:0]       kWide;
  logic [7:0]       shiftDown;
  logic [7:0]       placeShift;
  logic [OUT_W-1:0] chunk;

  always_comb begin
    room       = 8'(OUT_W) - 8'(fill);
    kWide      = minU8(8'(rem), room);
    shiftDown  = 8'(rem) - kWide;
    placeShift = room - kWide;
    // The isolated chunk is below 2^k <= 2^OUT_W, so truncating it is lossless.
    chunk      = OUT_W'((code >> shiftDown) & ~({CODE_W{1'b1}} << kWide));
    newWord    = word | (chunk << placeShift);
    k          = FILL_W'(kWide);
    newRem     = rem - LEN_W'(kWide);
  end

endmodule

// File: rtl/huffman_stream_encoder.sv
// Streaming Huffman encoder: table lookup per symbol, MSB-first packing into OUT_W-bit words.
// Define HUFF_ENC_STATS_EN to add the stat_syms / stat_bits counter ports.
module huffman_stream_encoder
  import huffman_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic                   clk,
  input  logic                   ctrl_reset,
  input  logic                   sym_valid,
  input  logic [SYM_W-1:0]       sym_data,
  input  logic                   sym_last,
  output logic                   sym_ready,
  output logic [SYM_W-1:0]       tbl_ascii,
  input  logic [CODE_W-1:0]      tbl_code,
  input  logic [LEN_W-1:0]       tbl_len,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic [$clog2(OUT_W):0] out_nbits,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   err_zero_len
`ifdef HUFF_ENC_STATS_EN
  ,
  output logic [31:0]            stat_syms,
  output logic [31:0]            stat_bits
`endif
);

  localparam int FILL_W = $clog2(OUT_W) + 1;

  encState_t         state, stateNext;
  logic [OUT_W-1:0]  word, wordNext;
  logic [FILL_W-1:0] fill, fillNext;
  logic [LEN_W-1:0]  rem, remNext;
  logic [CODE_W-1:0] code, codeNext;
  logic              lastFlag, lastNext;
  logic              errFlag, errNext;

  logic [OUT_W-1:0]  mergedWord;
  logic [FILL_W-1:0] mergeK;
  logic [LEN_W-1:0]  mergedRem;

  huff_bit_merge #(.OUT_W(OUT_W)) uMerge (
    .word    (word),
    .fill    (fill),
    .rem     (rem),
    .code    (code),
    .newWord (mergedWord),
    .k       (mergeK),
    .newRem  (mergedRem)
  );

  assign tbl_ascii    = sym_data;
  assign sym_ready    = (state == IDLE);
  assign out_valid    = (state == SEND);
  assign out_data     = (state == SEND) ? word : '0;
  assign out_nbits    = (state == SEND) ? fill : '0;
  assign out_last     = (state == SEND) && (rem == '0) && lastFlag;
  assign err_zero_len = errFlag;

  always_comb begin
    // NOTE: every next-value is defaulted first so no path through the case can infer a latch.
    stateNext = state;
    wordNext  = word;
    fillNext  = fill;
    remNext   = rem;
    codeNext  = code;
    lastNext  = lastFlag;
    errNext   = errFlag;
    unique case (state)
      IDLE: begin
        if (sym_valid) begin
          if (tbl_len == '0) begin
            // Unassigned symbol is dropped; a trailing one still flushes any partial word.
            errNext = 1'b1;
            if (sym_last && (fill != '0)) begin
              lastNext  = 1'b1;
              stateNext = SEND;
            end
          end else begin
            codeNext  = tbl_code;
            remNext   = tbl_len;
            lastNext  = sym_last;
            stateNext = EMIT;
          end
        end
      end
      EMIT: begin
        wordNext = mergedWord;
        fillNext = fill + mergeK;
        remNext  = mergedRem;
        if (fillNext == FILL_W'(OUT_W)) begin
          stateNext = SEND;
        end else if (mergedRem == '0) begin
          stateNext = lastFlag ? SEND : IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          wordNext = '0;
          fillNext = '0;
          if (rem != '0) begin
            stateNext = EMIT;
          end else begin
            lastNext  = 1'b0;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state    <= IDLE;
      word     <= '0;
      fill     <= '0;
      rem      <= '0;
      code     <= '0;
      lastFlag <= 1'b0;
      errFlag  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= stateNext;
      word     <= wordNext;
      fill     <= fillNext;
      rem      <= remNext;
      code     <= codeNext;
      lastFlag <= lastNext;
      errFlag  <= errNext;
    end
  end

`ifdef HUFF_ENC_STATS_EN
  logic [31:0] statSyms;
  logic [31:0] statBits;

  always_ff @(posedge clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      statSyms <= '0;
      statBits <= '0;
    end else begin
      if ((state == IDLE) && sym_valid && (tbl_len != '0)) begin
        statSyms <= statSyms + 32'd1;
      end
      if (state == EMIT) begin
        statBits <= statBits + 32'(mergeK);
      end
    end
  end

  assign stat_syms = statSyms;
  assign stat_bits = statBits;
`endif

endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Self-checking bench: directed cases plus random messages against a bit-queue
// reference model of the encoder's output word stream.
module tb_huffman_stream_encoder;
  import huffman_pkg::*;

  localparam int OUT_W = 32;
  localparam int NB_W  = $clog2(OUT_W) + 1;

  logic              clk = 1'b0;
  logic              ctrl_reset;
  logic              sym_valid;
  logic [SYM_W-1:0]  sym_data;
  logic              sym_last;
  logic              sym_ready;
  logic [SYM_W-1:0]  tbl_ascii;
  logic [CODE_W-1:0] tbl_code;
  logic [LEN_W-1:0]  tbl_len;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic [NB_W-1:0]   out_nbits;
  logic              out_last;
  logic              out_ready;
  logic              err_zero_len;
`ifdef HUFF_ENC_STATS_EN
  logic [31:0]       stat_syms;
  logic [31:0]       stat_bits;
`endif

  huffman_stream_encoder #(.OUT_W(OUT_W)) dut (
    .clk          (clk),
    .ctrl_reset   (ctrl_reset),
    .sym_valid    (sym_valid),
    .sym_data     (sym_data),
    .sym_last     (sym_last),
    .sym_ready    (sym_ready),
    .tbl_ascii    (tbl_ascii),
    .tbl_code     (tbl_code),
    .tbl_len      (tbl_len),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_nbits    (out_nbits),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .err_zero_len (err_zero_len)
`ifdef HUFF_ENC_STATS_EN
    ,
    .stat_syms    (stat_syms),
    .stat_bits    (stat_bits)
`endif
  );

  always #5 clk = ~clk;

  // Code table lives in the bench; read port is combinational.
  logic [CODE_W-1:0] tblCode [TABLE_DEPTH];
  logic [LEN_W-1:0]  tblLen  [TABLE_DEPTH];
  assign tbl_code = tblCode[tbl_ascii];
  assign tbl_len  = tblLen[tbl_ascii];

  typedef struct {
    logic [OUT_W-1:0] data;
    int               nbits;
    bit               last;
  } word_t;

  word_t gotQ[$];
  word_t expQ[$];
  int    msgSym[$];
  int    checks = 0;
  int    errors = 0;
  bit    modelErr;
  int    modelSyms;
  int    modelBits;
  int    readyMode;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sink: random or forced back-pressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: collect handshaken words and check that stalled words hold steady.
  bit    holding = 1'b0;
  word_t held;
  always @(negedge clk) begin
    if (ctrl_reset) begin
      holding = 1'b0;
    end else if (out_valid) begin
      if (holding) begin
        check("hold_data", out_data, held.data);
        check("hold_nbits", out_nbits, held.nbits);
        check("hold_last", out_last, held.last);
      end
      if (out_ready) begin
        gotQ.push_back('{out_data, int'(out_nbits), out_last});
        holding = 1'b0;
      end else begin
        holding = 1'b1;
        held    = '{out_data, int'(out_nbits), out_last};
      end
    end else begin
      if (holding) check("hold_valid", out_valid, 1);
      holding = 1'b0;
    end
  end

  // Reference: concatenate all assigned code bits MSB-first, then cut into words.
  task automatic build_expected();
    bit    bq[$];
    word_t w;
    int    total, pos, n, len;
    expQ.delete();
    foreach (msgSym[i]) begin
      len = int'(tblLen[msgSym[i]]);
      if (len == 0) begin
        modelErr = 1'b1;
      end else begin
        modelSyms++;
        modelBits += len;
        for (int b = len - 1; b >= 0; b--) bq.push_back(tblCode[msgSym[i]][b]);
      end
    end
    total = bq.size();
    pos   = 0;
    while (pos < total) begin
      n      = (total - pos < OUT_W) ? total - pos : OUT_W;
      w.data = '0;
      for (int i = 0; i < n; i++) w.data[OUT_W-1-i] = bq[pos+i];
      w.nbits = n;
      pos    += n;
      w.last  = (pos == total);
      expQ.push_back(w);
    end
    // A dropped final symbol with nothing pending ends the message without a flush word.
    if (expQ.size() > 0 && tblLen[msgSym[msgSym.size()-1]] == 0 && total % OUT_W == 0)
      expQ[expQ.size()-1].last = 1'b0;
  endtask

  task automatic send_sym(input int s, input bit last);
    int n = 0;
    sym_valid = 1'b1;
    sym_data  = SYM_W'(s);
    sym_last  = last;
    while (!sym_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("sym_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic send_msg(input bit gaps);
    build_expected();
    gotQ.delete();
    foreach (msgSym[i]) begin
      send_sym(msgSym[i], i == msgSym.size() - 1);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic finish_msg(input string tag);
    int n = 0;
    while (gotQ.size() < expQ.size() && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      check($sformatf("%s_w%0d_data", tag, i), gotQ[i].data, expQ[i].data);
      check($sformatf("%s_w%0d_nbits", tag, i), gotQ[i].nbits, expQ[i].nbits);
      check($sformatf("%s_w%0d_last", tag, i), gotQ[i].last, expQ[i].last);
    end
    check({tag, "_err"}, err_zero_len, modelErr);
    check({tag, "_idle"}, sym_ready, 1);
`ifdef HUFF_ENC_STATS_EN
    check({tag, "_stat_syms"}, stat_syms, modelSyms);
    check({tag, "_stat_bits"}, stat_bits, modelBits);
`endif
  endtask

  task automatic expect_word(input string tag, input int idx, input logic [OUT_W-1:0] data,
                             input int nbits, input bit last);
    if (gotQ.size() > idx) begin
      check({tag, "_data"}, gotQ[idx].data, data);
      check({tag, "_nbits"}, gotQ[idx].nbits, nbits);
      check({tag, "_last"}, gotQ[idx].last, last);
    end else begin
      check({tag, "_present"}, 0, 1);
    end
  endtask

  task automatic set_entry(input int s, input logic [CODE_W-1:0] c, input int len);
    tblCode[s] = c;
    tblLen[s]  = LEN_W'(len);
  endtask

  task automatic apply_reset();
    ctrl_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ctrl_reset = 1'b0;
    modelErr   = 1'b0;
    modelSyms  = 0;
    modelBits  = 0;
    gotQ.delete();
  endtask

  initial begin
    int r, len;
    ctrl_reset = 1'b1;
    sym_valid  = 1'b0;
    sym_data   = '0;
    sym_last   = 1'b0;
    out_ready  = 1'b1;
    readyMode  = 0;
    for (int i = 0; i < TABLE_DEPTH; i++) set_entry(i, '0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_sym_ready", sym_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_nbits", out_nbits, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err_zero_len, 0);
    apply_reset();
    @(posedge clk);
    #1;

    // 1: sixteen 2-bit codes exactly fill one word that ends the message.
    set_entry('h41, 128'b10, 2);
    msgSym = {};
    repeat (16) msgSym.push_back('h41);
    send_msg(0);
    finish_msg("t1");
    expect_word("t1_lit", 0, 32'hAAAAAAAA, 32, 1);

    // 2: two short codes share a partial word.
    set_entry('h61, 128'b10111, 5);
    set_entry('h62, 128'b001, 3);
    msgSym = {'h61, 'h62};
    send_msg(0);
    finish_msg("t2");
    expect_word("t2_lit", 0, 32'hB9000000, 8, 1);

    // 3: a 40-bit code spans two words.
    set_entry('h70, 128'hF0F0F0F0A5, 40);
    msgSym = {'h70};
    send_msg(0);
    finish_msg("t3");
    expect_word("t3_lit0", 0, 32'hF0F0F0F0, 32, 0);
    expect_word("t3_lit1", 1, 32'hA5000000, 8, 1);

    // 4: sink stalls for 10 cycles while a word is presented.
    readyMode = 2;
    out_ready = 1'b0;
    msgSym = {'h70};
    send_msg(0);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("t4_reach_send", out_valid, 1);
    end
    repeat (10) begin
      @(negedge clk);
      check("t4_sym_ready", sym_ready, 0);
      check("t4_out_valid", out_valid, 1);
    end
    readyMode = 0;
    finish_msg("t4");
    expect_word("t4_lit0", 0, 32'hF0F0F0F0, 32, 0);
    expect_word("t4_lit1", 1, 32'hA5000000, 8, 1);

    // 5: an unassigned symbol is dropped and flagged.
    set_entry('h00, '0, 0);
    set_entry('h63, 128'b111, 3);
    msgSym = {'h00, 'h63};
    send_msg(0);
    finish_msg("t5");
    expect_word("t5_lit", 0, 32'hE0000000, 3, 1);

    // 6: reset during EMIT of a 100-bit code aborts the message.
    set_entry('h64, {$urandom, $urandom, $urandom, $urandom}, 100);
    gotQ.delete();
    send_sym('h64, 1'b1);
    ctrl_reset = 1'b1;
    #1;
    check("t6_sym_ready", sym_ready, 1);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", out_data, 0);
    check("t6_out_nbits", out_nbits, 0);
    check("t6_out_last", out_last, 0);
    check("t6_err", err_zero_len, 0);
    apply_reset();
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_words", gotQ.size(), 0);
    set_entry('h65, 128'b101, 3);
    msgSym = {'h65};
    send_msg(0);
    finish_msg("t6_after");
    expect_word("t6_lit", 0, 32'hA0000000, 3, 1);

    // Random tables and messages under random back-pressure.
    readyMode = 1;
    for (int m = 0; m < 40; m++) begin
      for (int s = 0; s < TABLE_DEPTH; s++) begin
        r = $urandom_range(0, 99);
        if (r < 8)       len = 0;
        else if (r < 75) len = $urandom_range(1, 12);
        else if (r < 92) len = $urandom_range(13, 40);
        else             len = $urandom_range(41, 127);
        set_entry(s, {$urandom, $urandom, $urandom, $urandom}, len);
      end
      msgSym = {};
      repeat ($urandom_range(1, 10)) msgSym.push_back($urandom_range(0, TABLE_DEPTH - 1));
      send_msg(1);
      finish_msg($sformatf("rnd%0d", m));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
